// File: rtl/frame_stat_counter.sv
// rtl/frame_stat_counter.sv - per-frame / per-timer-window multi-channel event counter
//
// Purpose: counts per-channel event strobes (high cycles or rising edges) over a
// gate window bounded either by the active I_vs edge or by GATE_CYCLES clocks,
// and latches the counts into shadow registers for readout.
//
// Ports:
//   I_clk        sole clock
//   I_rst        synchronous active-high reset
//   I_vs         frame sync, active level VS_POL
//   I_event      per-channel event strobes
//   I_edge_mode  per channel: 1 = count rising edges, 0 = count high cycles
//   I_gate_sel   0 = frame gating, 1 = timer gating
//   I_rd_sel     channel shown on O_count / O_ovf_sel
//   O_count      latched count of the selected channel
//   O_ovf_sel    latched overflow flag of the selected channel
//   O_overflow   latched overflow flags, all channels
//   O_valid      one-cycle pulse when a new snapshot is latched
//   O_frame_cnt  number of snapshots taken (wraps)
//   O_blink      toggles on every snapshot
module frame_stat_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 24,
  parameter int GATE_CYCLES = 48_000_000,
  parameter int VS_POL      = 1,
  parameter int SEL_W       = 2
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_vs,
  input  logic [NUM_CH-1:0]    I_event,
  input  logic [NUM_CH-1:0]    I_edge_mode,
  input  logic                 I_gate_sel,
  input  logic [SEL_W-1:0]     I_rd_sel,
  output logic [CNT_WIDTH-1:0] O_count,
  output logic                 O_ovf_sel,
  output logic [NUM_CH-1:0]    O_overflow,
  output logic                 O_valid,
  output logic [15:0]          O_frame_cnt,
  output logic                 O_blink
);

  localparam int   GC_W   = $clog2(GATE_CYCLES);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic {WAIT_SYNC, COUNT} state_t;

  state_t               state, state_nx;
  logic                 gate_sel_q;
  logic                 vs_q;
  logic [NUM_CH-1:0]    prev;
  logic [NUM_CH-1:0]    qev;
  logic [NUM_CH-1:0]    ovf;
  logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow [NUM_CH];
  logic [GC_W-1:0]      gate_cnt;
  logic                 mode_chg, vs_edge, timer_end, boundary;
  logic                 snap, start, cnt_run;
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic                 sel_ovf;

  assign mode_chg  = (I_gate_sel != gate_sel_q);
  assign vs_edge   = (I_vs == VS_ACT) && (vs_q != VS_ACT);
  assign timer_end = (gate_cnt == GC_W'(GATE_CYCLES - 1));
  assign boundary  = gate_sel_q ? timer_end : vs_edge;
  // Edge-mode channels qualify with ~prev; level-mode channels pass straight through.
  assign qev       = I_event & ~(I_edge_mode & prev);

  always_ff @(posedge I_clk) begin
    if (I_rst) state <= WAIT_SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    snap     = 1'b0;
    start    = 1'b0;
    cnt_run  = 1'b0;
    if (mode_chg) begin
      // Gating mode changed: drop the partial window and resynchronise.
      state_nx = WAIT_SYNC;
    end else begin
      case (state)
        WAIT_SYNC: begin
          if (gate_sel_q || vs_edge) begin
            start    = 1'b1;
            state_nx = COUNT;
          end
        end
        COUNT: begin
          if (boundary) snap    = 1'b1;
          else          cnt_run = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      // Track the live gate select through reset so release never looks like a mode change.
      gate_sel_q  <= I_gate_sel;
      vs_q        <= ~VS_ACT;
      prev        <= '1;
      ovf         <= '0;
      gate_cnt    <= '0;
      O_overflow  <= '0;
      O_valid     <= 1'b0;
      O_frame_cnt <= 16'd0;
      O_blink     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      gate_sel_q <= I_gate_sel;
      vs_q       <= I_vs;
      prev       <= I_event;
      O_valid    <= snap;

      if (start) begin
        gate_cnt <= '0;
        ovf      <= '0;
        for (int i = 0; i < NUM_CH; i++)
          cnt[i] <= gate_sel_q ? '0 : CNT_WIDTH'(qev[i]);
      end

      if (snap) begin
        gate_cnt    <= '0;
        O_overflow  <= ovf;
        ovf         <= '0;
        O_frame_cnt <= O_frame_cnt + 16'd1;
        O_blink     <= ~O_blink;
        // The boundary-cycle event opens the new window.
        for (int i = 0; i < NUM_CH; i++) begin
          shadow[i] <= cnt[i];
          cnt[i]    <= CNT_WIDTH'(qev[i]);
        end
      end

      if (cnt_run) begin
        if (gate_sel_q) gate_cnt <= gate_cnt + GC_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (qev[i]) begin
            if (&cnt[i]) ovf[i] <= 1'b1;
            else         cnt[i] <= cnt[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Out-of-range selects match no channel and read as zero.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (I_rd_sel == SEL_W'(i)) begin
        sel_cnt = shadow[i];
        sel_ovf = O_overflow[i];
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_count   <= '0;
      O_ovf_sel <= 1'b0;
    end else begin
      O_count   <= sel_cnt;
      O_ovf_sel <= sel_ovf;
    end
  end

endmodule

// File: tb/tb_frame_stat_counter.sv
// tb/tb_frame_stat_counter.sv - directed self-checking bench for frame_stat_counter
module tb_frame_stat_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic [3:0]  ev;
  logic [3:0]  edge_mode;
  logic        gate_sel;
  logic [2:0]  rd_sel;

  logic [23:0] a_count;
  logic        a_ovf_sel;
  logic [3:0]  a_overflow;
  logic        a_valid;
  logic [15:0] a_frame_cnt;
  logic        a_blink;

  logic [7:0]  b_count;
  logic        b_ovf_sel;
  logic [3:0]  b_overflow;
  logic        b_valid;
  logic [15:0] b_frame_cnt;
  logic        b_blink;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  frame_stat_counter #(
    .NUM_CH(4), .CNT_WIDTH(24), .GATE_CYCLES(1000), .VS_POL(1), .SEL_W(3)
  ) dut_a (
    .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_event(ev), .I_edge_mode(edge_mode),
    .I_gate_sel(gate_sel), .I_rd_sel(rd_sel),
    .O_count(a_count), .O_ovf_sel(a_ovf_sel), .O_overflow(a_overflow),
    .O_valid(a_valid), .O_frame_cnt(a_frame_cnt), .O_blink(a_blink)
  );

  frame_stat_counter #(
    .NUM_CH(4), .CNT_WIDTH(8), .GATE_CYCLES(1000), .VS_POL(1), .SEL_W(3)
  ) dut_b (
    .I_clk(clk), .I_rst(rst), .I_vs(vs), .I_event(ev), .I_edge_mode(edge_mode),
    .I_gate_sel(gate_sel), .I_rd_sel(rd_sel),
    .O_count(b_count), .O_ovf_sel(b_ovf_sel), .O_overflow(b_overflow),
    .O_valid(b_valid), .O_frame_cnt(b_frame_cnt), .O_blink(b_blink)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // One-cycle vs pulse; O_valid is checked in the cycle after the boundary,
  // and on return O_count already reflects the new snapshot.
  task automatic vs_pulse(input string tag, input logic exp_valid);
    vs = 1'b1;
    step(1);
    check(tag, a_valid, exp_valid);
    vs = 1'b0;
    step(1);
  endtask

  task automatic run_level(input int ch, input int n);
    ev[ch] = 1'b1;
    step(n);
    ev[ch] = 1'b0;
    step(2);
  endtask

  task automatic run_pulses(input int ch, input int n, input int hi, input int lo);
    for (int k = 0; k < n; k++) begin
      ev[ch] = 1'b1;
      step(hi);
      ev[ch] = 1'b0;
      step(lo);
    end
  endtask

  initial begin
    int t_prev;
    int t_rel;
    int waited;

    rst = 1'b1; vs = 1'b0; ev = 4'b0; edge_mode = 4'b0; gate_sel = 1'b0; rd_sel = 3'd0;
    step(3);
    check("rst_count",     a_count,     0);
    check("rst_ovf_sel",   a_ovf_sel,   0);
    check("rst_overflow",  a_overflow,  0);
    check("rst_valid",     a_valid,     0);
    check("rst_frame_cnt", a_frame_cnt, 0);
    check("rst_blink",     a_blink,     0);
    rst = 1'b0;
    step(2);

    // Frame mode, ch0 level counting.
    vs_pulse("f1_first_vs_valid", 1'b0);
    run_level(0, 3000);
    vs_pulse("f1_valid", 1'b1);
    check("f1_count",     a_count,     3000);
    check("f1_overflow",  a_overflow,  0);
    check("f1_frame_cnt", a_frame_cnt, 1);
    check("f1_blink",     a_blink,     1);

    // ch1 edge mode, then level mode on the same stimulus.
    rd_sel = 3'd1;
    edge_mode = 4'b0010;
    run_pulses(1, 48, 20, 12);
    vs_pulse("f2_valid", 1'b1);
    check("f2_edge_count", a_count, 48);
    edge_mode = 4'b0000;
    run_pulses(1, 48, 20, 12);
    vs_pulse("f3_valid", 1'b1);
    check("f3_level_count", a_count, 960);
    check("f3_frame_cnt", a_frame_cnt, 3);

    // Event on the boundary cycle belongs to the new window.
    rd_sel = 3'd3;
    ev[3] = 1'b1; vs = 1'b1;
    step(1);
    check("col_valid", a_valid, 1);
    ev[3] = 1'b0; vs = 1'b0;
    step(1);
    check("col_current", a_count, 0);
    step(5);
    vs_pulse("col_next_valid", 1'b1);
    check("col_next", a_count, 1);
    rd_sel = 3'd7;
    step(1);
    check("sel_oob_count", a_count, 0);
    check("sel_oob_ovf",   a_ovf_sel, 0);

    // Saturation on the 8-bit instance.
    rd_sel = 3'd0;
    run_level(0, 300);
    vs_pulse("sat_valid", 1'b1);
    check("sat_count_b",    b_count, 255);
    check("sat_ovf_b",      b_overflow[0], 1);
    check("sat_ovf_sel_b",  b_ovf_sel, 1);
    check("sat_count_a",    a_count, 300);
    run_level(0, 10);
    vs_pulse("sat2_valid", 1'b1);
    check("sat2_count_b",   b_count, 10);
    check("sat2_ovf_b",     b_overflow[0], 0);

    // Reset mid-window.
    ev[0] = 1'b1;
    step(50);
    rst = 1'b1;
    step(1);
    check("mrst_count",     a_count, 0);
    check("mrst_frame_cnt", a_frame_cnt, 0);
    check("mrst_overflow",  a_overflow, 0);
    check("mrst_valid",     a_valid, 0);
    check("mrst_blink",     a_blink, 0);
    rst = 1'b0; ev[0] = 1'b0;
    step(2);
    vs_pulse("mrst_first_vs", 1'b0);
    run_level(0, 5);
    vs_pulse("mrst_second_vs", 1'b1);
    check("mrst_frame_after", a_frame_cnt, 1);
    check("mrst_count_after", a_count, 5);

    // Gate-select toggle mid-window discards the window.
    run_level(0, 20);
    gate_sel = 1'b1;
    step(1);
    gate_sel = 1'b0;
    step(3);
    run_level(0, 8);
    vs_pulse("mchg_vs_valid", 1'b0);
    check("mchg_frame_hold", a_frame_cnt, 1);
    run_level(0, 7);
    vs_pulse("mchg_next_valid", 1'b1);
    check("mchg_frame_next", a_frame_cnt, 2);
    check("mchg_count", a_count, 7);

    // Timer mode from reset, ch2 constantly high.
    gate_sel = 1'b1; rst = 1'b1; ev = 4'b0100; rd_sel = 3'd2;
    step(2);
    rst = 1'b0;
    t_rel  = cyc;
    t_prev = cyc;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (!a_valid && waited < 1200) begin
        step(1);
        waited++;
      end
      if (!a_valid) begin
        check($sformatf("tmr_timeout_%0d", k), 0, 1);
        break;
      end
      if (k == 0) check("tmr_first_latency", cyc - t_rel, 1001);
      else        check($sformatf("tmr_gap_%0d", k), cyc - t_prev, 1000);
      check($sformatf("tmr_blink_%0d", k), a_blink, (k == 1) ? 0 : 1);
      t_prev = cyc;
      step(1);
      if (k > 0) check($sformatf("tmr_count_%0d", k), a_count, 1000);
    end
    check("tmr_frame_cnt", a_frame_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_stat_counter.md
# frame_stat_counter

Parametrised per-frame event counter for debug and bring-up. It generalises the free-running one-second debug counter into NUM_CH independent channels. Each channel counts level-high cycles or rising edges of a strobe (e.g. cmos_write_en, cmos_href) over a gate window. The window is either one video frame, bounded by vsync, or a fixed number of clock cycles. Snapshots are latched for readout over PMOD/UART print control, and a toggle output replaces the 1-second blink.

## Interface
- NUM_CH, 4: number of counted channels (1..16)
- CNT_WIDTH, 24: width of each channel counter and of O_count
- GATE_CYCLES, 48_000_000: window length in timer mode, in I_clk cycles (≥2)
- VS_POL, 1: active level of I_vs (1: rising edge starts a frame, 0: falling edge)
- SEL_W, 2: width of I_rd_sel (≥ clog2(NUM_CH), ≥1)

Ports:
- I_clk  in  1  sole clock; all inputs synchronous to it
- I_rst  in  1  synchronous, active-high reset
- I_vs  in  1  frame sync, polarity per VS_POL
- I_event  in  NUM_CH  per-channel event strobes
- I_edge_mode  in  NUM_CH  per channel: 1 = count rising edges, 0 = count high cycles
- I_gate_sel  in  1  0 = frame gating by I_vs, 1 = timer gating by GATE_CYCLES
- I_rd_sel  in  SEL_W  channel shown on O_count / O_ovf_sel
- O_count  out  CNT_WIDTH  latched count of selected channel
- O_ovf_sel  out  1  latched overflow flag of selected channel
- O_overflow  out  NUM_CH  latched overflow flags, all channels
- O_valid  out  1  one-cycle pulse: new snapshot latched
- O_frame_cnt  out  16  number of snapshots taken, wraps
- O_blink  out  1  toggles on each snapshot

## Operation
- States: WAIT_SYNC and COUNT. Reset enters WAIT_SYNC.
- Boundary, frame mode: the active edge of I_vs. This is I_vs at active level while the previous-cycle registered I_vs was inactive.
- Boundary, timer mode: in COUNT with gate_cnt == GATE_CYCLES-1. gate_cnt counts 0..GATE_CYCLES-1 and clears on every boundary.
- WAIT_SYNC, frame mode: wait for a boundary. On it, clear counters, load the current-cycle events, go to COUNT. No snapshot.
- WAIT_SYNC, timer mode: exactly one cycle. Clear counters and gate_cnt, go to COUNT. No snapshot.
- COUNT, non-boundary cycle: each channel increments if its qualified event is 1.
  - Level mode: qualified event = I_event[i].
  - Edge mode: qualified event = I_event[i] & ~prev[i].
- COUNT, boundary cycle:
  - Copy the counters and overflow flags to the shadow registers.
  - Reload the counters with this cycle's qualified event (0 or 1). An event on the boundary cycle belongs to the new window.
  - Clear the live overflow flags.
- Saturation: a counter at all-ones holds its value and sets its live overflow flag for the remainder of the window.
- I_gate_sel is registered. Any change returns the block to WAIT_SYNC, discarding the partial window. Shadows are kept and no O_valid is issued.
- I_edge_mode changes take effect immediately, with no restart.
- prev[i] is registered I_event[i]. It resets to all-ones so that an input already high after reset does not count as an edge.
- O_count and O_ovf_sel mux the shadows by I_rd_sel. If I_rd_sel ≥ NUM_CH, both outputs are 0.
- O_frame_cnt increments on each snapshot and wraps 0xFFFF→0. O_blink toggles on each snapshot.

## Timing
- Reset values: O_count=0, O_ovf_sel=0, O_overflow=0, O_valid=0, O_frame_cnt=0, O_blink=0. Shadows, counters and gate_cnt are 0; prev is all-ones.
- Snapshot latency: shadows, O_overflow, O_frame_cnt, O_blink and O_valid update at the clock edge that ends the boundary cycle. O_valid is high for exactly that one following cycle.
- O_count/O_ovf_sel are registered. They update 1 cycle after an I_rd_sel change, or in the cycle after O_valid.
- Timer mode: consecutive O_valid pulses are exactly GATE_CYCLES cycles apart. The first pulse comes GATE_CYCLES+1 cycles after reset release.
- Frame mode: O_valid follows every active I_vs edge except the first one after reset or a mode change.
- Reset mid-window: all state returns to reset values on the next edge, and the partial window is lost.

## Test plan
- Frame mode, ch0 level mode, CNT_WIDTH=24: I_event[0] high 307200 cycles per frame, two vs edges → one O_valid after the 2nd edge; O_count=307200, O_overflow=0, O_frame_cnt=1.
- Frame mode, ch1 edge mode: 480 pulses of 1280 cycles high per frame, I_rd_sel=1 → O_count=480. Level mode on the same stimulus → O_count=614400.
- Timer mode, GATE_CYCLES=1000, I_event[2] constant high → O_valid every 1000 cycles, O_count=1000, O_blink alternating 1,0,1.
- Saturation, CNT_WIDTH=8: 300 events in window 1 → O_count=255, O_overflow[0]=1. Then 10 events in window 2 → O_count=10, O_overflow[0]=0.
- Boundary collision: event high only on the vs boundary cycle → that event appears in the next snapshot (1), not the current one (0). I_rd_sel=7 with NUM_CH=4 → O_count=0.
- Reset/mode change: assert I_rst mid-window → all outputs 0 next cycle, first vs after release gives no O_valid, second vs does. Toggling I_gate_sel mid-window → no O_valid and O_frame_cnt unchanged until the next complete window.
